// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD up/down counter.
//   BCD_W     : width of one BCD decade
//   BCD_MAX   : largest legal digit value (9)
//   BCD_MIN   : smallest legal digit value (0)
//   bcd_valid : true when a 4-bit value is a legal BCD digit
package bcd_pkg;
    localparam int           BCD_W   = 4;
    localparam logic [3:0]   BCD_MAX = 4'd9;
    localparam logic [3:0]   BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
        return (digit <= BCD_MAX);
    endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade of the up/down counter.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   step       : advance this decade by one in direction 'up'
//   up         : 1 = increment, 0 = decrement
//   clr        : synchronous clear (highest priority)
//   load       : synchronous load of load_digit (invalid digits load as 0)
//   load_digit : digit value to load
//   digit      : registered digit value
//   is_max     : digit == 9
//   is_min     : digit == 0
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    output logic [BCD_W-1:0] digit,
    output logic             is_max,
    output logic             is_min
);

    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_digit <= BCD_MIN;
        end else if (clr) begin
            r_digit <= BCD_MIN;
        end else if (load) begin
            r_digit <= bcd_valid(load_digit) ? load_digit : BCD_MIN;
        end else if (step) begin
            // '>=' rather than '==' so that an impossible non-BCD value
            // still returns to a legal digit instead of counting on.
            if (up) begin
                r_digit <= (r_digit >= BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == BCD_MIN || r_digit > BCD_MAX) ?
                           BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    assign digit  = r_digit;
    assign is_max = (r_digit == BCD_MAX);
    assign is_min = (r_digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with synchronous clear/load and
// optional saturation at the limits.
// Parameters:
//   DIGITS   : number of BCD decades (1..8)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   en       : count enable, one step per cycle
//   up       : 1 = increment, 0 = decrement
//   clr      : synchronous clear (priority over load and en)
//   load     : synchronous load of load_val (priority over en)
//   load_val : BCD value to load, digit i at [4i+3:4i]
//   count    : registered BCD count
//   tc       : combinational terminal count, for cascading into en of
//              the next instance
//   ovf      : registered one-cycle pulse after an up step at max
//   udf      : registered one-cycle pulse after a down step at min
//   load_err : registered one-cycle pulse after a load with a bad digit
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  udf,
    output logic                  load_err
);

    logic [DIGITS-1:0] w_is_max;
    logic [DIGITS-1:0] w_is_min;
    logic [DIGITS:0]   w_low_max;   // bit i: decades 0..i-1 are all 9
    logic [DIGITS:0]   w_low_min;   // bit i: decades 0..i-1 are all 0
    logic [DIGITS-1:0] w_step;
    logic [DIGITS-1:0] w_digit_bad;
    logic              w_all_max;
    logic              w_all_min;
    logic              w_at_limit;
    logic              w_hold;
    logic              w_count_cycle;
    logic              w_ovf_next;
    logic              w_udf_next;
    logic              w_lerr_next;

    logic              r_ovf;
    logic              r_udf;
    logic              r_load_err;

    assign w_low_max[0] = 1'b1;
    assign w_low_min[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_low_max[gi+1] = w_low_max[gi] & w_is_max[gi];
            assign w_low_min[gi+1] = w_low_min[gi] & w_is_min[gi];

            // Ripple enable: a decade moves only when every lower decade
            // is about to roll over in the current direction.
            assign w_step[gi] = en & ~w_hold &
                                (up ? w_low_max[gi] : w_low_min[gi]);

            assign w_digit_bad[gi] = ~bcd_valid(load_val[gi*BCD_W +: BCD_W]);

            bcd_digit_cell u_cell (
                .clk        (clk),
                .rst        (rst),
                .step       (w_step[gi]),
                .up         (up),
                .clr        (clr),
                .load       (load),
                .load_digit (load_val[gi*BCD_W +: BCD_W]),
                .digit      (count[gi*BCD_W +: BCD_W]),
                .is_max     (w_is_max[gi]),
                .is_min     (w_is_min[gi])
            );
        end
    endgenerate

    assign w_all_max  = w_low_max[DIGITS];
    assign w_all_min  = w_low_min[DIGITS];
    assign w_at_limit = up ? w_all_max : w_all_min;

    // In saturate mode a step at the limit is suppressed entirely, so
    // every decade holds. In wrap mode all decades roll over together.
    assign w_hold = SATURATE & w_at_limit;

    assign tc = en & w_at_limit;

    // Only a genuine count cycle (no clr, no load) may raise ovf/udf.
    assign w_count_cycle = en & ~clr & ~load;
    assign w_ovf_next    = w_count_cycle &  up & w_all_max;
    assign w_udf_next    = w_count_cycle & ~up & w_all_min;
    assign w_lerr_next   = ~clr & load & (|w_digit_bad);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_ovf      <= w_ovf_next;
            r_udf      <= w_udf_next;
            r_load_err <= w_lerr_next;
        end
    end

    assign ovf      = r_ovf;
    assign udf      = r_udf;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 99;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] count0, count1;
    logic         tc0, tc1, ovf0, ovf1, udf0, udf1, le0, le1;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count0), .tc(tc0), .ovf(ovf0),
        .udf(udf0), .load_err(le0)
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1), .ovf(ovf1),
        .udf(udf1), .load_err(le1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: count kept as a plain integer 0..MAXV.
    int m_cnt [2];
    bit m_ovf [2];
    bit m_udf [2];
    bit m_le  [2];

    typedef struct {
        logic         clr, load, en, up;
        logic [W-1:0] lv;
        logic [W-1:0] cnt;
        logic         ovf, udf, le;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int decode(input logic [W-1:0] lv, output bit err);
        int v, p;
        logic [3:0] d;
        v = 0; p = 1; err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = lv[4*i +: 4];
            if (d > 4'd9) begin
                err = 1'b1;
                d = 4'd0;
            end
            v = v + int'(d) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic bit m_tc(input int s);
        return en && (up ? (m_cnt[s] == MAXV) : (m_cnt[s] == 0));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0; m_ovf[s] = 0; m_udf[s] = 0; m_le[s] = 0;
        end
    endtask

    task automatic model_edge();
        bit e;
        int v;
        for (int s = 0; s < 2; s++) begin
            m_ovf[s] = 0; m_udf[s] = 0; m_le[s] = 0;
            if (clr) begin
                m_cnt[s] = 0;
            end else if (load) begin
                v = decode(load_val, e);
                m_cnt[s] = v;
                m_le[s]  = e;
            end else if (en) begin
                if (up) begin
                    if (m_cnt[s] == MAXV) begin
                        m_ovf[s] = 1;
                        m_cnt[s] = (s == 1) ? MAXV : 0;
                    end else m_cnt[s] = m_cnt[s] + 1;
                end else begin
                    if (m_cnt[s] == 0) begin
                        m_udf[s] = 1;
                        m_cnt[s] = (s == 1) ? 0 : MAXV;
                    end else m_cnt[s] = m_cnt[s] - 1;
                end
            end
        end
    endtask

    task automatic set_in(input logic c, input logic l, input logic e,
                          input logic u, input logic [W-1:0] lv);
        clr = c; load = l; en = e; up = u; load_val = lv;
    endtask

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge after checking both DUTs against the model.
    task automatic cycle();
        #1;
        chk("tc0", 32'(tc0), 32'(m_tc(0)));
        chk("tc1", 32'(tc1), 32'(m_tc(1)));
        @(posedge clk);
        model_edge();
        #1;
        chk("cnt0", 32'(count0), 32'(to_bcd(m_cnt[0])));
        chk("cnt1", 32'(count1), 32'(to_bcd(m_cnt[1])));
        chk("ovf0", 32'(ovf0), 32'(m_ovf[0]));
        chk("ovf1", 32'(ovf1), 32'(m_ovf[1]));
        chk("udf0", 32'(udf0), 32'(m_udf[0]));
        chk("udf1", 32'(udf1), 32'(m_udf[1]));
        chk("le0", 32'(le0), 32'(m_le[0]));
        chk("le1", 32'(le1), 32'(m_le[1]));
        $display("txn c=%0b l=%0b e=%0b u=%0b lv=%h -> cnt0=%h cnt1=%h o=%0b%0b u=%0b%0b le=%0b",
                 clr, load, en, up, load_val, count0, count1, ovf0, ovf1, udf0, udf1, le0);
        @(negedge clk);
    endtask

    // Reset pulse asserted between edges; outputs must clear at once.
    task automatic mid_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_cnt0", 32'(count0), 32'h0);
        chk("rst_cnt1", 32'(count1), 32'h0);
        chk("rst_ovf", 32'({ovf0, ovf1}), 32'h0);
        chk("rst_udf", 32'({udf0, udf1}), 32'h0);
        chk("rst_le", 32'({le0, le1}), 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                                input logic [W-1:0] lv, input logic [W-1:0] cnt,
                                input logic o, input logic d, input logic le);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up = u; v.lv = lv;
        v.cnt = cnt; v.ovf = o; v.udf = d; v.le = le;
        return v;
    endfunction

    initial begin
        int n_ovf, n_tc, r;

        // Expected results for the wrapping instance, applied in order.
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h4C, 8'h40, 1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h47, 8'h47, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h48, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 1'b0);

        model_reset();
        @(negedge clk);
        chk("init_cnt0", 32'(count0), 32'h0);
        chk("init_ovf0", 32'(ovf0), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-count at 37, then count up from 00.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h37);
        cycle();
        chk("pre_rst_37", 32'(count0), 32'h37);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        mid_reset();
        cycle();
        chk("post_rst_01", 32'(count0), 32'h01);

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].lv);
            cycle();
            chk($sformatf("tbl%0d_cnt", i), 32'(count0), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf0), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_udf", i), 32'(udf0), 32'(tbl[i].udf));
            chk($sformatf("tbl%0d_le", i), 32'(le0), 32'(tbl[i].le));
        end

        // 100 up steps from 00: one ovf with count 00, tc only at 99.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        n_ovf = 0; n_tc = 0;
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (tc0) n_tc++;
            cycle();
            if (ovf0) begin
                n_ovf++;
                chk("wrap_cnt00", 32'(count0), 32'h00);
            end
        end
        chk("wrap_ovf_n", 32'(n_ovf), 32'd1);
        chk("wrap_tc_n", 32'(n_tc), 32'd1);

        // Saturation: held at 99 with ovf on every step, then down to 98.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        cycle();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("sat_cnt99", 32'(count1), 32'h99);
            chk("sat_ovf", 32'(ovf1), 32'h1);
        end
        up = 1'b0;
        cycle();
        chk("sat_dn98", 32'(count1), 32'h98);
        chk("sat_ovf_off", 32'(ovf1), 32'h0);

        // Idle hold with tc low.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_tc", 32'(tc0), 32'h0);
            cycle();
        end

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            clr  = (r < 3);
            load = (r >= 3 && r < 10);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) != 0;
            load_val = W'($urandom);
            if (load && $urandom_range(0, 1) == 1)
                load_val = ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h00;
            if (i == 200) mid_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
